// File: rtl/dualport_ram_param_if.sv
// One RAM access port: request (en/rw/address/data_in) and registered response (data_out/valid).
interface dualport_ram_param_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic              en;
  logic              rw;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              valid;

  modport master (output en, rw, address, data_in, input  data_out, valid);
  modport slave  (input  en, rw, address, data_in, output data_out, valid);
endinterface

// File: rtl/dualport_ram_param.sv
// True dual-port synchronous RAM, port A wins write collisions, RDW_MODE selects old/new read data.
// Define DPRAM_OUTREG_EN for an extra output register stage (latency 2).
module dualport_ram_param #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 8,
  parameter int RDW_MODE = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  dualport_ram_param_if.slave   port_a,
  dualport_ram_param_if.slave   port_b,
  output logic                  collision
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam int NP    = 2;
`ifdef DPRAM_OUTREG_EN
  localparam int STAGES = 2;
`else
  localparam int STAGES = 1;
`endif

  typedef struct packed {
    logic              en;
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] din;
  } req_t;

  req_t [NP-1:0]             req;
  logic [NP-1:0]             acc;
  logic [NP-1:0]             wr;
  logic [NP-1:0][DATA_W-1:0] dout;
  logic [NP-1:0]             vout;
  logic                      coll;
  logic [STAGES:0]           col_pipe;

  logic [DATA_W-1:0] mem [DEPTH];

  assign req[0] = {port_a.en, port_a.rw, port_a.address, port_a.data_in};
  assign req[1] = {port_b.en, port_b.rw, port_b.address, port_b.data_in};

  // Nothing is accepted while reset is held, including array writes.
  for (genvar p = 0; p < NP; p++) begin : g_acc
    assign acc[p] = rst_n & req[p].en;
    assign wr[p]  = acc[p] & req[p].rw;
  end

  assign coll = wr[0] & wr[1] & (req[0].addr == req[1].addr);

  // Array is never reset; port B's write is dropped when it collides with A.
  always_ff @(posedge clk) begin
    if (wr[1] && !coll) mem[req[1].addr] <= req[1].din;
    if (wr[0])          mem[req[0].addr] <= req[0].din;
  end

  for (genvar p = 0; p < NP; p++) begin : g_port
    logic [STAGES:0]   vld_pipe;
    logic [DATA_W-1:0] dpipe [STAGES:1];
    logic [DATA_W-1:0] byp;

    // New-data mode forwards the stored write value; A is checked first so collisions return A's data.
    always_comb begin
      byp = mem[req[p].addr];
      if (RDW_MODE != 0) begin
        if (wr[0] && (req[0].addr == req[p].addr))      byp = req[0].din;
        else if (wr[1] && (req[1].addr == req[p].addr)) byp = req[1].din;
      end
    end

    assign vld_pipe[0] = acc[p];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int k = 1; k <= STAGES; k++) begin
          vld_pipe[k] <= 1'b0;
          dpipe[k]    <= '0;
        end
      end else begin
        vld_pipe[1] <= vld_pipe[0];
        if (vld_pipe[0]) dpipe[1] <= byp;
        for (int k = 2; k <= STAGES; k++) begin
          vld_pipe[k] <= vld_pipe[k-1];
          if (vld_pipe[k-1]) dpipe[k] <= dpipe[k-1];
        end
      end
    end

    assign dout[p] = dpipe[STAGES];
    assign vout[p] = vld_pipe[STAGES];
  end

  assign col_pipe[0] = coll;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_pipe[STAGES:1] <= '0;
    end else begin
      for (int k = 1; k <= STAGES; k++) col_pipe[k] <= col_pipe[k-1];
    end
  end

  assign collision       = col_pipe[STAGES];
  assign port_a.data_out = dout[0];
  assign port_a.valid    = vout[0];
  assign port_b.data_out = dout[1];
  assign port_b.valid    = vout[1];
endmodule
